// File: rtl/store_aligner_pkg.sv
// Shared store/load path definitions: funct3 size codes, store FSM states and the byte-mask helper.
package store_aligner_pkg;

  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;

  typedef enum logic [2:0] {
    StIdle,
    StWr0,
    StWr1,
    StDone,
    StFault
  } state_e;

  // Unsupported sizes yield an empty mask.
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3)
      F3_B:    size_mask = 4'b0001;
      F3_H:    size_mask = 4'b0011;
      F3_W:    size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane placement: shifts store data and strobes across a two-word window.
module store_lane_align
  import store_aligner_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  output logic [63:0] wdata_o,
  output logic [7:0]  wstrb_o,
  output logic        split_o
);

  assign wdata_o = {32'b0, data_i} << {offset_i, 3'b000};
  assign wstrb_o = {4'b0000, size_mask(funct3_i)} << offset_i;
  assign split_o = |wstrb_o[7:4];

endmodule

// File: rtl/store_aligner.sv
// Store aligner: byte-lane placement, word writes over valid/ready, optional split of
// word-crossing stores (STORE_MISALIGN_SPLIT_EN; without it such stores fault).
module store_aligner
  import store_aligner_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid_i,
  output logic              st_ready_o,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [31:0]       st_data_i,
  input  logic [2:0]        funct3_i,
  output logic              st_done_o,
  output logic              st_fault_o,
  output logic              mem_we_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_din_o,
  output logic [3:0]        mem_wstrb_o
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [2:0]        f3_q;

  logic              in_idle;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_data;
  logic [2:0]        sel_f3;
  logic [63:0]       wdata;
  logic [7:0]        wstrb;
  logic              split;
  logic              legal;
  logic              reject;

  assign in_idle    = (state_q == StIdle);
  assign st_ready_o = in_idle;

  // Live inputs drive beat0 at acceptance; the captured request drives beat1 later.
  assign sel_addr = in_idle ? st_addr_i : addr_q;
  assign sel_data = in_idle ? st_data_i : data_q;
  assign sel_f3   = in_idle ? funct3_i  : f3_q;

  store_lane_align u_lane_align (
    .data_i   (sel_data),
    .funct3_i (sel_f3),
    .offset_i (sel_addr[1:0]),
    .wdata_o  (wdata),
    .wstrb_o  (wstrb),
    .split_o  (split)
  );

  assign legal = (sel_f3 == F3_B) || (sel_f3 == F3_H) || (sel_f3 == F3_W);

`ifdef STORE_MISALIGN_SPLIT_EN
  assign reject = !legal;
`else
  assign reject = !legal || split || ((sel_f3 == F3_H) && (sel_addr[1:0] == 2'b01));
  logic unused_hi;
  assign unused_hi = ^wdata[63:32];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      data_q      <= '0;
      f3_q        <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_din_o   <= '0;
      mem_wstrb_o <= '0;
      st_done_o   <= 1'b0;
      st_fault_o  <= 1'b0;
    end else begin
      st_done_o  <= 1'b0;
      st_fault_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (st_valid_i) begin
            addr_q <= st_addr_i;
            data_q <= st_data_i;
            f3_q   <= funct3_i;
            if (reject) begin
              st_done_o  <= 1'b1;
              st_fault_o <= 1'b1;
              state_q    <= StFault;
            end else begin
              mem_addr_o  <= {st_addr_i[ADDR_W-1:2], 2'b00};
              mem_din_o   <= wdata[31:0];
              mem_wstrb_o <= wstrb[3:0];
              mem_we_o    <= 1'b1;
              state_q     <= StWr0;
            end
          end
        end
        StWr0: begin
          if (mem_ready_i) begin
`ifdef STORE_MISALIGN_SPLIT_EN
            if (split) begin
              mem_addr_o  <= mem_addr_o + ADDR_W'(4);
              mem_din_o   <= wdata[63:32];
              mem_wstrb_o <= wstrb[7:4];
              state_q     <= StWr1;
            end else begin
              mem_we_o  <= 1'b0;
              st_done_o <= 1'b1;
              state_q   <= StDone;
            end
`else
            mem_we_o  <= 1'b0;
            st_done_o <= 1'b1;
            state_q   <= StDone;
`endif
          end
        end
`ifdef STORE_MISALIGN_SPLIT_EN
        StWr1: begin
          if (mem_ready_i) begin
            mem_we_o  <= 1'b0;
            st_done_o <= 1'b1;
            state_q   <= StDone;
          end
        end
`endif
        StDone:  state_q <= StIdle;
        StFault: state_q <= StIdle;
        default: begin
          mem_we_o <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_aligner.sv
// Self-checking bench for store_aligner; follows STORE_MISALIGN_SPLIT_EN like the RTL.
module tb_store_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  funct3;
  logic        st_done;
  logic        st_fault;
  logic        mem_we;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_wstrb;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  store_aligner #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_valid_i  (st_valid),
    .st_ready_o  (st_ready),
    .st_addr_i   (st_addr),
    .st_data_i   (st_data),
    .funct3_i    (funct3),
    .st_done_o   (st_done),
    .st_fault_o  (st_fault),
    .mem_we_o    (mem_we),
    .mem_ready_i (mem_ready),
    .mem_addr_o  (mem_addr),
    .mem_din_o   (mem_din),
    .mem_wstrb_o (mem_wstrb)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a store writes 'size' consecutive byte addresses; each distinct word touched is
  // one beat. Lane data is the source byte whose address lands there (zero outside the store).
  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                           input int stall);
    int          size;
    bit          fault;
    int          nb;
    logic [31:0] b_addr[2];
    logic [31:0] b_din[2];
    logic [3:0]  b_strb[2];
    size  = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : (f == 3'd2) ? 4 : 0;
    fault = (size == 0);
`ifndef STORE_MISALIGN_SPLIT_EN
    if (int'(a[1:0]) + size > 4 || (size == 2 && a[1:0] == 2'd1)) fault = 1'b1;
`endif
    nb = 0;
    if (!fault) begin
      for (int k = 0; k < size; k++) begin
        logic [31:0] ba;
        ba = a + 32'(k);
        if (nb == 0 || {ba[31:2], 2'b00} != b_addr[nb-1]) begin
          b_addr[nb] = {ba[31:2], 2'b00};
          b_strb[nb] = 4'b0000;
          nb++;
        end
        b_strb[nb-1][ba[1:0]] = 1'b1;
      end
      for (int b = 0; b < nb; b++) begin
        b_din[b] = 32'h0;
        for (int l = 0; l < 4; l++) begin
          logic [31:0] idx;
          idx = b_addr[b] + 32'(l) - a;
          if (idx < 4) b_din[b][8*l +: 8] = d[8*idx[1:0] +: 8];
        end
      end
    end

    chk("ready_before_req", st_ready, 1);
    st_valid  = 1'b1;
    st_addr   = a;
    st_data   = d;
    funct3    = f;
    mem_ready = 1'b0;
    @(negedge clk);
    st_valid = 1'b0;
    st_addr  = $urandom;
    st_data  = $urandom;
    funct3   = 3'($urandom);

    if (fault) begin
      chk("fault_done", st_done, 1);
      chk("fault_flag", st_fault, 1);
      chk("fault_no_we", mem_we, 0);
      chk("fault_not_ready", st_ready, 0);
      @(negedge clk);
      chk("fault_pulse_end", st_done, 0);
      chk("fault_flag_end", st_fault, 0);
      chk("fault_idle_no_we", mem_we, 0);
      chk("fault_idle_ready", st_ready, 1);
      return;
    end

    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i <= stall; i++) begin
        chk("beat_we", mem_we, 1);
        chk("beat_addr", mem_addr, b_addr[b]);
        chk("beat_din", mem_din, b_din[b]);
        chk("beat_strb", mem_wstrb, b_strb[b]);
        chk("busy_not_ready", st_ready, 0);
        chk("busy_no_done", st_done, 0);
        // Requests presented while busy must be ignored.
        st_valid  = 1'($urandom);
        st_addr   = $urandom;
        st_data   = $urandom;
        funct3    = 3'($urandom);
        mem_ready = (i == stall);
        @(negedge clk);
      end
    end
    mem_ready = 1'b0;
    st_valid  = 1'b0;
    chk("done_pulse", st_done, 1);
    chk("done_no_fault", st_fault, 0);
    chk("done_we_low", mem_we, 0);
    chk("done_addr_hold", mem_addr, b_addr[nb-1]);
    chk("done_din_hold", mem_din, b_din[nb-1]);
    chk("done_strb_hold", mem_wstrb, b_strb[nb-1]);
    @(negedge clk);
    chk("done_pulse_end", st_done, 0);
    chk("idle_ready", st_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_addr   = 32'h0;
    st_data   = 32'h0;
    funct3    = 3'd0;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_din, 0);
    chk("rst_strb", mem_wstrb, 0);
    chk("rst_done", st_done, 0);
    chk("rst_fault", st_fault, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", st_ready, 1);

    run_store(32'h0000_0100, 32'hDEAD_BEEF, 3'b010, 0);
    run_store(32'h0000_0203, 32'h0000_00A5, 3'b000, 0);
    run_store(32'h0000_0302, 32'h0000_1234, 3'b001, 3);
    run_store(32'h0000_0403, 32'h1122_3344, 3'b010, 1);
    run_store(32'hFFFF_FFFE, 32'hCAFE_F00D, 3'b010, 0);
    run_store(32'h0000_0500, 32'h5555_5555, 3'b011, 0);
    run_store(32'h0000_0601, 32'h0000_BEEF, 3'b001, 2);

    // Reset while a write is outstanding: aborts with no completion pulse.
    st_valid  = 1'b1;
    funct3    = 3'b010;
    st_data   = 32'h1122_3344;
`ifdef STORE_MISALIGN_SPLIT_EN
    st_addr   = 32'h0000_0403;
    mem_ready = 1'b1;
    @(negedge clk);
    st_valid  = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("abort_wr1_addr", mem_addr, 32'h0000_0404);
`else
    st_addr   = 32'h0000_0400;
    mem_ready = 1'b0;
    @(negedge clk);
    st_valid  = 1'b0;
    chk("abort_wr0_addr", mem_addr, 32'h0000_0400);
`endif
    chk("abort_we_before", mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_async", mem_we, 0);
    chk("abort_no_done", st_done, 0);
    @(negedge clk);
    chk("abort_no_done_later", st_done, 0);
    rst_n = 1'b1;
    chk("abort_ready", st_ready, 1);
    @(negedge clk);
    chk("abort_idle_no_done", st_done, 0);
    chk("abort_idle_no_we", mem_we, 0);
    run_store(32'h0000_0701, 32'h0000_007E, 3'b000, 1);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic [2:0]  f;
      int          r;
      r = int'($urandom_range(0, 9));
      f = (r < 3) ? 3'b000 : (r < 6) ? 3'b001 : (r < 9) ? 3'b010 : 3'($urandom_range(3, 7));
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else a = $urandom;
      run_store(a, $urandom, f, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_aligner.md
Name: store_aligner

Overview:
- Write-side counterpart of the load sign-extension path: takes SB/SH/SW store requests from the execute stage, places the data on the correct byte lanes and generates byte strobes.
- Drives word-aligned writes to data memory over a valid/ready handshake and stalls the core until the store has completed.
- A misaligned store that crosses a word boundary is split into two sequential word writes.

Parameters:
- ADDR_W, 32, byte address width. Memory addresses are ADDR_W bits; bits [1:0] of mem_addr are always 0.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  store request from the core.
- st_ready  out  1  block can accept a request (high in IDLE only).
- st_addr  in  ADDR_W  byte address.
- st_data  in  32  rs2 value; the low 8/16/32 bits are used.
- funct3  in  3  000=SB, 001=SH, 010=SW.
- st_done  out  1  one-cycle pulse when the store has completed or faulted.
- st_fault  out  1  qualifies st_done: request rejected, no memory write performed.
- mem_we  out  1  write request valid.
- mem_ready  in  1  memory accepts the write when mem_we && mem_ready.
- mem_addr  out  ADDR_W  word-aligned write address.
- mem_din  out  32  lane-aligned write data.
- mem_wstrb  out  4  byte enables; bit i covers mem_din[8i+7:8i].

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE.
  - mem_we=0, mem_addr=0, mem_din=0, mem_wstrb=0.
  - st_done=0, st_fault=0.
  - st_ready=1 once reset is released.
- Size mask: SB=0001, SH=0011, SW=1111.
- Offset: o=st_addr[1:0].
- Alignment arithmetic: 64-bit wide data W = {32'b0, st_data} << (8*o); 8-bit strobe S = mask << o.
  - Beat0: addr = {st_addr[ADDR_W-1:2], 2'b00}, din = W[31:0], wstrb = S[3:0].
  - Beat1: addr = beat0 addr + 4, modulo 2^ADDR_W (wraps to 0), din = W[63:32], wstrb = S[7:4].
  - A split is needed iff S[7:4] != 0.
- Acceptance:
  - A request is accepted when st_valid && st_ready. Address, data and funct3 are registered on acceptance.
  - Inputs are ignored in every other state.
- States:
  - IDLE: on acceptance, an illegal funct3 (anything other than 000/001/010) → FAULT. Otherwise load beat0 into the memory output registers, set mem_we=1 → WR0.
  - WR0: hold all mem_* stable until mem_ready.
    - If mem_ready and a split is needed: load beat1 next cycle, keep mem_we=1 → WR1.
    - If mem_ready and no split: mem_we=0 → DONE.
  - WR1: hold until mem_ready, then mem_we=0 → DONE.
  - DONE: st_done=1 and st_fault=0 for exactly one cycle → IDLE.
  - FAULT: st_done=1 and st_fault=1 for one cycle, no write issued → IDLE.
- Latency: an aligned store with mem_ready tied high has acceptance at cycle 0, write at cycle 1, st_done at cycle 2. A split store adds one cycle.
- mem_din and mem_wstrb must not change while mem_we=1 and mem_ready=0. mem_we never drops without a handshake.
- mem_addr, mem_din and mem_wstrb keep their last value when mem_we=0. No X on any output after reset.
- st_ready is low in WR0, WR1, DONE and FAULT, so back-to-back requests cost at least one IDLE cycle each.
- Reset mid-write (WR0/WR1) aborts immediately: mem_we=0, no st_done pulse, and the remaining beat is lost.

Optional Feature:
- Macro: STORE_MISALIGN_SPLIT_EN.
- Defined: misaligned stores are split as described above.
- Undefined: any store where S[7:4] != 0, or SH with o=1, goes to FAULT (st_done=1, st_fault=1). No memory write occurs and WR1 is not synthesized. Aligned stores behave identically in both builds.

Decomposition:
- Shared package (shared with the load path):
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010.
  - State enum IDLE/WR0/WR1/DONE/FAULT.
  - Size-mask function.
- Sub-module store_lane_align: combinational; (data, funct3, offset) → 64-bit data, 8-bit strobe, split flag.
- The FSM and output registers live in store_aligner.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, mem_ready=1 → one write at addr 0x100, din 0xDEADBEEF, wstrb 1111; st_done at cycle 2, st_fault=0.
- SB addr=0x203, data=0x000000A5 → one write at addr 0x200, din 0xA5000000, wstrb 1000.
- SH addr=0x302, data=0x1234, mem_ready low for 3 cycles → mem_we, din 0x12340000 and wstrb 1100 held stable for 4 cycles; st_done the cycle after the handshake.
- SW addr=0x403, data=0x11223344 (split build):
  - Beat0: addr 0x400, din 0x44000000, wstrb 1000.
  - Beat1: addr 0x404, din 0x00112233, wstrb 0111.
  - Non-split build: fault pulse, no mem_we.
- SW addr=0xFFFFFFFE, split build → beat1 at addr 0x00000000 with wstrb 0011. Then funct3=011 → FAULT pulse, mem_we stays 0.
- rst_n low during WR1 → mem_we=0 asynchronously, no st_done; after release st_ready=1 and a new SB completes normally.
